// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;
   localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MULT = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Width of an iteration counter that must hold values 0..w-1.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/muldiv_iter_counter.sv
// Loadable down-counter that paces the WIDTH iterations of a multiply or divide.
module muldiv_iter_counter
   import muldiv_pkg::*;
#(
   parameter int CW = MULDIV_CNT_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          terminal
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign terminal = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Signed Booth multiply / restoring divide sequencer feeding the Hi/Lo registers.
// Optional build macro MULDIV_UNSIGNED_EN adds op_unsigned for multu/divu.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef MULDIV_UNSIGNED_EN
   input  logic             op_unsigned,
`endif
   output logic             busy,
   output logic             done,
   output logic             hilo_write,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [2:0]       dbg_state
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   state_t state, next_state;

   logic accept_mult, accept_div, accept_zero;
   logic step, terminal, uns_in;
   logic [CW-1:0] count;

   // acc is the upper half of the product (one guard bit) or the remainder;
   // lo_q is the multiplier/low product or the dividend/quotient.
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] lo_q;
   logic             qm1;
   logic [WIDTH:0]   mcand;
   logic [WIDTH-1:0] divisor;
   logic             is_div, is_uns, neg_q, neg_r;

   logic [WIDTH:0]   booth_sum;
   logic             shift_in;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic             restore;
   logic [WIDTH-1:0] fix_hi, fix_lo;
   logic [WIDTH-1:0] mag_a, mag_b;

`ifdef MULDIV_UNSIGNED_EN
   assign uns_in = op_unsigned;
`else
   assign uns_in = 1'b0;
`endif

   assign dbg_state = state;
   assign step      = (state == MULT) || (state == DIV);

   muldiv_iter_counter #(.CW(CW)) u_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (accept_mult | accept_div),
      .load_value (LAST_COUNT),
      .dec        (step),
      .count      (count),
      .terminal   (terminal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      accept_mult = 1'b0;
      accept_div  = 1'b0;
      accept_zero = 1'b0;
      case (state)
         IDLE: begin
            if (mult_start) begin
               next_state  = MULT;
               accept_mult = 1'b1;
            end else if (div_start) begin
               if (op_b != '0) begin
                  next_state = DIV;
                  accept_div = 1'b1;
               end else begin
                  next_state  = DONE;
                  accept_zero = 1'b1;
               end
            end
         end
         MULT, DIV: begin
            if (terminal) next_state = FIX;
         end
         FIX:     next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         hilo_write <= 1'b0;
         div_zero   <= 1'b0;
      end else begin
         busy       <= (next_state != IDLE);
         done       <= (next_state == DONE);
         hilo_write <= (next_state == DONE) && !accept_zero;
         div_zero   <= accept_zero;
      end
   end

   // Booth step: unsigned mode degenerates to plain shift-add with a logical shift.
   always_comb begin
      booth_sum = acc;
      if (is_uns) begin
         if (lo_q[0]) booth_sum = acc + mcand;
      end else begin
         case ({lo_q[0], qm1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
         endcase
      end
      shift_in = is_uns ? 1'b0 : booth_sum[WIDTH];
   end

   assign shifted = {acc[WIDTH-1:0], lo_q[WIDTH-1]};
   assign trial   = {1'b0, shifted} - {2'b00, divisor};
   assign restore = trial[WIDTH+1];

   assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
   assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

   always_comb begin
      fix_hi = acc[WIDTH-1:0];
      fix_lo = lo_q;
      if (is_div) begin
         if (neg_r) fix_hi = -acc[WIDTH-1:0];
         if (neg_q) fix_lo = -lo_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         lo_q    <= '0;
         qm1     <= 1'b0;
         mcand   <= '0;
         divisor <= '0;
         is_div  <= 1'b0;
         is_uns  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         hi_out  <= '0;
         lo_out  <= '0;
      end else if (accept_mult) begin
         acc    <= '0;
         lo_q   <= op_b;
         qm1    <= 1'b0;
         mcand  <= uns_in ? {1'b0, op_a} : {op_a[WIDTH-1], op_a};
         is_div <= 1'b0;
         is_uns <= uns_in;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (accept_div) begin
         acc     <= '0;
         lo_q    <= uns_in ? op_a : mag_a;
         divisor <= uns_in ? op_b : mag_b;
         is_div  <= 1'b1;
         is_uns  <= uns_in;
         neg_q   <= !uns_in && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
         neg_r   <= !uns_in && op_a[WIDTH-1];
      end else if (state == MULT) begin
         acc  <= {shift_in, booth_sum[WIDTH:1]};
         lo_q <= {booth_sum[0], lo_q[WIDTH-1:1]};
         qm1  <= lo_q[0];
      end else if (state == DIV) begin
         // The remainder stays below the divisor, so bit WIDTH of acc is always 0 here.
         acc  <= restore ? shifted : trial[WIDTH:0];
         lo_q <= {lo_q[WIDTH-2:0], ~restore};
      end else if (state == FIX) begin
         hi_out <= fix_hi;
         lo_out <= fix_lo;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: transaction-level reference model plus directed literals.
module tb_muldiv_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         mult_start = 1'b0;
   logic         div_start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
`ifdef MULDIV_UNSIGNED_EN
   logic         op_unsigned = 1'b0;
`endif
   logic         busy, done, hilo_write, div_zero;
   logic [W-1:0] hi_out, lo_out;
   logic [2:0]   dbg_state;
   logic         uns_s;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .op_a       (op_a),
      .op_b       (op_b),
`ifdef MULDIV_UNSIGNED_EN
      .op_unsigned(op_unsigned),
`endif
      .busy       (busy),
      .done       (done),
      .hilo_write (hilo_write),
      .div_zero   (div_zero),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .dbg_state  (dbg_state)
   );

`ifdef MULDIV_UNSIGNED_EN
   assign uns_s = op_unsigned;
`else
   assign uns_s = 1'b0;
`endif

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: results computed with plain 64-bit arithmetic
   function automatic logic [63:0] ref_result(input bit is_mul, input bit uns,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] res;
      sa = uns ? longint'({32'b0, a}) : longint'($signed(a));
      sb = uns ? longint'({32'b0, b}) : longint'($signed(b));
      if (is_mul) begin
         p   = sa * sb;
         res = p;
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         res = {r[31:0], q[31:0]};
      end
      return res;
   endfunction

   logic [63:0]  exp_q[$];
   logic         m_busy = 1'b0, m_done = 1'b0, m_hw = 1'b0, m_dz = 1'b0, m_in_done = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int           m_left = 0;

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_busy = 0; m_done = 0; m_hw = 0; m_dz = 0; m_in_done = 0;
            m_hi = '0; m_lo = '0; m_left = 0;
            exp_q.delete();
         end else begin
            m_done = 0; m_hw = 0; m_dz = 0;
            if (m_in_done) begin
               m_in_done = 0;
               m_busy    = 0;
            end else if (m_busy) begin
               m_left--;
               if (m_left == 0) begin
                  m_in_done    = 1;
                  m_done       = 1;
                  m_hw         = 1;
                  {m_hi, m_lo} = exp_q.pop_front();
               end
            end else if (mult_start) begin
               m_busy = 1;
               m_left = W + 1;
               exp_q.push_back(ref_result(1'b1, uns_s, op_a, op_b));
            end else if (div_start) begin
               m_busy = 1;
               if (op_b == '0) begin
                  m_in_done = 1;
                  m_done    = 1;
                  m_dz      = 1;
               end else begin
                  m_left = W + 1;
                  exp_q.push_back(ref_result(1'b0, uns_s, op_a, op_b));
               end
            end
         end
      end
   end

   // scoreboard compare on every falling edge
   initial begin
      @(posedge reset);
      forever begin
         @(negedge clk);
         check("cycle{busy,done,hw,dz,hi,lo}",
               {busy, done, hilo_write, div_zero, hi_out, lo_out},
               {m_busy, m_done, m_hw, m_dz, m_hi, m_lo});
      end
   end

   // driver: one-cycle start pulse, then wait (bounded) for done; lat=1 is the cycle after accept
   task automatic do_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, output int lat);
      @(negedge clk);
      mult_start = m;
      div_start  = d;
      op_a       = a;
      op_b       = b;
      @(negedge clk);
      mult_start = 1'b0;
      div_start  = 1'b0;
      op_a       = $urandom();
      op_b       = $urandom();
      lat        = 1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         div_start = (lat == inj);
      end
      div_start = 1'b0;
      check("done_seen", {71'b0, done}, 72'd1);
   endtask

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0;
         3:       return 32'h1;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int lat;
      int extra_done;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", {71'b0, busy}, 72'd0);
      check("reset_done", {71'b0, done}, 72'd0);
      check("reset_hilo", {8'b0, hi_out, lo_out}, 72'd0);
      reset = 1'b0;

      // 7 * -3
      do_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, lat);
      check("mul_latency", 72'(lat), 72'd34);
      check("mul_hi", 72'(hi_out), 72'hFFFF_FFFF);
      check("mul_lo", 72'(lo_out), 72'hFFFF_FFEB);
      check("mul_hw", {71'b0, hilo_write}, 72'd1);
      check("model_mul_hilo", {8'b0, m_hi, m_lo}, 72'hFFFF_FFFF_FFFF_FFEB);

      // -7 / 2
      do_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, lat);
      check("div_latency", 72'(lat), 72'd34);
      check("div_lo", 72'(lo_out), 72'hFFFF_FFFD);
      check("div_hi", 72'(hi_out), 72'hFFFF_FFFF);

      // overflow case wraps silently
      do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
      check("ovf_lo", 72'(lo_out), 72'h8000_0000);
      check("ovf_hi", 72'(hi_out), 72'h0);
      check("ovf_dz", {71'b0, div_zero}, 72'd0);

      // divide by zero: immediate, no write, Hi/Lo untouched
      do_op(0, 1, 32'd5, 32'd0, 0, lat);
      check("dz_latency", 72'(lat), 72'd1);
      check("dz_flag", {71'b0, div_zero}, 72'd1);
      check("dz_hw", {71'b0, hilo_write}, 72'd0);
      check("dz_hilo_kept", {8'b0, hi_out, lo_out}, {8'b0, 32'h0, 32'h8000_0000});

      // both starts: multiply wins; stray div_start at cycle 10 ignored
      do_op(1, 1, 32'd3, 32'd5, 10, lat);
      check("both_hilo", {8'b0, hi_out, lo_out}, 72'd15);
      @(negedge clk);
      check("both_busy_drop", {71'b0, busy}, 72'd0);
      extra_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("both_single_done", 72'(extra_done), 72'd0);

      // reset at cycle 15 of a divide
      @(negedge clk);
      div_start = 1'b1; op_a = 32'd1000; op_b = 32'd7;
      @(negedge clk);
      div_start = 1'b0;
      repeat (14) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_busy", {71'b0, busy}, 72'd0);
      check("rst_mid_hw", {71'b0, hilo_write}, 72'd0);
      check("rst_mid_hilo", {8'b0, hi_out, lo_out}, 72'd0);
      @(negedge clk);
      reset = 1'b0;
      do_op(1, 0, 32'h0001_0000, 32'h0001_0000, 0, lat);
      check("post_rst_mul", {8'b0, hi_out, lo_out}, {8'b0, 32'h1, 32'h0});

`ifdef MULDIV_UNSIGNED_EN
      op_unsigned = 1'b1;
      do_op(1, 0, 32'hFFFF_FFFF, 32'd2, 0, lat);
      check("multu", {8'b0, hi_out, lo_out}, {8'b0, 32'h1, 32'hFFFF_FFFE});
      op_unsigned = 1'b1;
      do_op(0, 1, 32'hFFFF_FFFF, 32'h10, 0, lat);
      check("divu", {8'b0, hi_out, lo_out}, {8'b0, 32'hF, 32'h0FFF_FFFF});
      op_unsigned = 1'b0;
`endif

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         int kind;
         logic [W-1:0] a, b;
         kind = $urandom_range(0, 9);
         a    = rand_op();
         b    = rand_op();
`ifdef MULDIV_UNSIGNED_EN
         op_unsigned = 1'($urandom_range(0, 1));
`endif
         if (kind <= 3)      do_op(1, 0, a, b, $urandom_range(0, 40), lat);
         else if (kind <= 7) do_op(0, 1, a, (b == '0) ? 32'd3 : b, $urandom_range(0, 40), lat);
         else if (kind == 8) do_op(1, 1, a, b, $urandom_range(0, 40), lat);
         else                do_op(0, 1, a, 32'd0, 0, lat);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "time limit");
   end

endmodule
